sd_cmd_phy: RTL and testbench
=============================

SD_CMD_PHY -- requirements
Module: sd_cmd_phy

Interface
REQ-001 SHALL have port sd_clock, input, 1, the single SD-card clock; all logic is on its rising edge.
REQ-002 SHALL have port reset_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port strobe_in, input, 1, a one-cycle request to send a command, sampled only in IDLE.
REQ-004 SHALL have port cmd_index, input, 6, the command index, captured on an accepted strobe_in.
REQ-005 SHALL have port cmd_arg, input, 32, the command argument, captured on an accepted strobe_in.
REQ-006 SHALL have port resp_expected, input, 1, where 1 means a 48-bit response is awaited.
REQ-007 SHALL have port crc_check_en, input, 1, where 1 means the response CRC7 is checked (0 for R3).
REQ-008 SHALL have port ack_in, input, 1, which releases DONE.
REQ-009 SHALL have port pad_oe, output, 1, connecting to the CMD pad direction (1 = drive).
REQ-010 SHALL have port pad_enable, output, 1, connecting to the CMD pad enable.
REQ-011 SHALL have port pad_data_out, output, 1, the serial bit to the pad.
REQ-012 SHALL have port pad_data_in, input, 1, the serial bit received from the pad.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done, output, 1, held high in DONE until ack_in.
REQ-015 SHALL have port resp_index, output, 6, response bits 45:40.
REQ-016 SHALL have port resp_arg, output, 32, response bits 39:8.
REQ-017 SHALL have ports timeout_err, crc_err and frame_err, output, 1 each, the status flags, valid while done=1.

Function
REQ-018 SHALL build a 48-bit transmit frame, sent MSB first: start bit 0, transmission bit 1, index, arg, CRC7 (x^7+x^3+1, seed 0, computed over bits 47:8), end bit 1.
REQ-019 SHALL implement states IDLE, SEND, TURN, WAIT_START, RECEIVE, CHECK, DONE.
REQ-020 SHALL, in IDLE, accept strobe_in=1 and enter SEND on the next edge; strobe_in in any other state is ignored.
REQ-021 SHALL, in SEND, present one frame bit per cycle on pad_data_out with pad_oe=1 and pad_enable=1, for exactly 48 cycles.
REQ-022 SHALL, after SEND, go to DONE with all flags 0 if resp_expected=0, and otherwise go to TURN.
REQ-023 SHALL, in TURN, hold pad_oe=0 and pad_enable=1 for 2 cycles, covering the pad's one-cycle registered latency in each direction, then go to WAIT_START.
REQ-024 SHALL, in WAIT_START, sample pad_data_in each cycle: a 0 enters RECEIVE; after 64 samples with no 0, set timeout_err=1 and go to DONE.
REQ-025 SHALL, in RECEIVE, shift in the remaining 47 bits MSB first, then go to CHECK.
REQ-026 SHALL, in CHECK (one cycle), set frame_err=1 if the transmission bit is not 0 or the end bit is not 1.
REQ-027 SHALL, in CHECK, set crc_err=1 if crc_check_en=1 and the received bits 7:1 differ from the CRC7 of bits 47:8; CHECK then goes to DONE.
REQ-028 SHALL, in DONE, hold done and the response outputs stable; ack_in=1 returns the block to IDLE on the next edge.
REQ-029 SHALL, if ack_in and strobe_in are both high in DONE, honour the ack only; the strobe is not accepted.
REQ-030 SHALL keep pad_oe=0 in every state except SEND.
REQ-031 SHALL keep pad_enable=0 in IDLE and DONE.
REQ-032 SHALL clear the flags on an accepted strobe_in.

Reset
REQ-033 SHALL, when reset_n=0 at a rising edge, force state IDLE from any state, including mid-SEND or mid-RECEIVE.
REQ-034 SHALL reset pad_oe, pad_enable, busy, done and all flags to 0, pad_data_out to 1, and resp_index and resp_arg to 0.

Structure
REQ-035 SHALL place the state encoding and the constants FRAME_BITS=48, NCR_MAX=64, TURN_CYCLES=2 and CRC7_POLY=7'h09 in a shared package, sd_cmd_pkg.
REQ-036 SHALL implement CRC7 as the sub-module sd_crc7 (bit-serial, with clear and enable), instantiated once for transmit and once for receive.

Verification
REQ-037 SHALL cover: CMD0 with arg 0x00000000 and resp_expected=0 -> serial stream 0x400000000095 over 48 cycles, then done=1 with all flags 0.
REQ-038 SHALL cover: CMD17 with arg 0x00000000 -> serial stream 0x510000000055; model returns a valid R1 with a correct CRC -> done=1, crc_err=0, resp_index=17.
REQ-039 SHALL cover: response with one CRC bit flipped -> crc_err=1; the same stimulus with crc_check_en=0 -> crc_err=0.
REQ-040 SHALL cover: line held at 1 after TURN -> timeout_err=1 exactly 64 cycles after WAIT_START is entered.
REQ-041 SHALL cover: reset_n=0 at bit 20 of SEND -> next edge IDLE, pad_oe=0, busy=0; a following strobe_in sends a full frame.
REQ-042 SHALL cover: strobe_in pulsed during SEND, and strobe_in together with ack_in in DONE -> both ignored, and exactly one frame is sent per accepted strobe.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD-line PHY: controller state encoding,
// frame and timing constants, and the single-bit CRC7 update.
package sd_cmd_pkg;

    localparam int FRAME_BITS  = 48;
    localparam int NCR_MAX     = 64;
    localparam int TURN_CYCLES = 2;
    localparam logic [6:0] CRC7_POLY = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_TURN,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // One LFSR step of x^7 + x^3 + 1, message bit entering at the top.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 accumulator with synchronous clear and per-bit enable.
module sd_crc7
    import sd_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic       bit_i,
    output logic [6:0] crc_o
);

    logic [6:0] crc_q;
    logic [6:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear_i) begin
            crc_d = '0;
        end else if (enable_i) begin
            crc_d = crc7_step(crc_q, bit_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises a 48-bit command frame, optionally waits for
// and deserialises a 48-bit response, then reports status until acknowledged.
module sd_cmd_phy
    import sd_cmd_pkg::*;
(
    input  logic        sd_clock,
    input  logic        reset_n,
    input  logic        strobe_in,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_expected,
    input  logic        crc_check_en,
    input  logic        ack_in,
    output logic        pad_oe,
    output logic        pad_enable,
    output logic        pad_data_out,
    input  logic        pad_data_in,
    output logic        busy,
    output logic        done,
    output logic [5:0]  resp_index,
    output logic [31:0] resp_arg,
    output logic        timeout_err,
    output logic        crc_err,
    output logic        frame_err
);

    localparam logic [6:0] SEND_LAST    = 7'(FRAME_BITS - 1);
    localparam logic [6:0] PAYLOAD_BITS = 7'(FRAME_BITS - 8);
    localparam logic [6:0] TURN_LAST    = 7'(TURN_CYCLES - 1);
    localparam logic [6:0] NCR_LAST     = 7'(NCR_MAX - 1);
    localparam logic [6:0] RECV_LAST    = 7'(FRAME_BITS - 2);
    localparam logic [6:0] RX_CRC_BITS  = 7'(FRAME_BITS - 9);

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [39:0] tx_shift_q, tx_shift_d;
    logic [46:0] rx_shift_q, rx_shift_d;   // start bit is implied, bits 46..0 kept
    logic        resp_exp_q, resp_exp_d;
    logic        crc_en_q, crc_en_d;
    logic        tmo_q, tmo_d;
    logic        crc_err_q, crc_err_d;
    logic        frm_err_q, frm_err_d;
    logic [5:0]  resp_index_q, resp_index_d;
    logic [31:0] resp_arg_q, resp_arg_d;

    logic        accept;
    logic [6:0]  tx_crc;
    logic [6:0]  rx_crc;

    assign accept = (state_q == ST_IDLE) && strobe_in;

    sd_crc7 u_tx_crc (
        .clk_i    (sd_clock),
        .rst_n_i  (reset_n),
        .clear_i  (accept),
        .enable_i ((state_q == ST_SEND) && (cnt_q < PAYLOAD_BITS)),
        .bit_i    (tx_shift_q[39]),
        .crc_o    (tx_crc)
    );

    // The leading start bit is 0 and leaves a zero-seeded CRC unchanged, so
    // accumulation starts with the transmission bit.
    sd_crc7 u_rx_crc (
        .clk_i    (sd_clock),
        .rst_n_i  (reset_n),
        .clear_i  (accept),
        .enable_i ((state_q == ST_RECEIVE) && (cnt_q < RX_CRC_BITS)),
        .bit_i    (pad_data_in),
        .crc_o    (rx_crc)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_shift_d   = tx_shift_q;
        rx_shift_d   = rx_shift_q;
        resp_exp_d   = resp_exp_q;
        crc_en_d     = crc_en_q;
        tmo_d        = tmo_q;
        crc_err_d    = crc_err_q;
        frm_err_d    = frm_err_q;
        resp_index_d = resp_index_q;
        resp_arg_d   = resp_arg_q;

        case (state_q)
            ST_IDLE: begin
                if (strobe_in) begin
                    state_d    = ST_SEND;
                    cnt_d      = '0;
                    tx_shift_d = {2'b01, cmd_index, cmd_arg};
                    resp_exp_d = resp_expected;
                    crc_en_d   = crc_check_en;
                    tmo_d      = 1'b0;
                    crc_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                end
            end
            ST_SEND: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q < PAYLOAD_BITS) begin
                    tx_shift_d = {tx_shift_q[38:0], 1'b0};
                end
                if (cnt_q == SEND_LAST) begin
                    cnt_d   = '0;
                    state_d = resp_exp_q ? ST_TURN : ST_DONE;
                end
            end
            ST_TURN: begin
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (!pad_data_in) begin
                    state_d    = ST_RECEIVE;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                end else if (cnt_q == NCR_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ST_RECEIVE: begin
                rx_shift_d = {rx_shift_q[45:0], pad_data_in};
                cnt_d      = cnt_q + 7'd1;
                if (cnt_q == RECV_LAST) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                frm_err_d    = rx_shift_q[46] | ~rx_shift_q[0];
                crc_err_d    = crc_en_q & (rx_shift_q[7:1] != rx_crc);
                resp_index_d = rx_shift_q[45:40];
                resp_arg_d   = rx_shift_q[39:8];
                state_d      = ST_DONE;
            end
            ST_DONE: begin
                if (ack_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            resp_exp_q   <= 1'b0;
            crc_en_q     <= 1'b0;
            tmo_q        <= 1'b0;
            crc_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            resp_index_q <= '0;
            resp_arg_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            resp_exp_q   <= resp_exp_d;
            crc_en_q     <= crc_en_d;
            tmo_q        <= tmo_d;
            crc_err_q    <= crc_err_d;
            frm_err_q    <= frm_err_d;
            resp_index_q <= resp_index_d;
            resp_arg_q   <= resp_arg_d;
        end
    end

    // Frame bit order on the wire: 40 payload bits, 7 CRC bits, end bit.
    always_comb begin
        pad_data_out = 1'b1;
        if (state_q == ST_SEND) begin
            if (cnt_q < PAYLOAD_BITS) begin
                pad_data_out = tx_shift_q[39];
            end else if (cnt_q < SEND_LAST) begin
                pad_data_out = tx_crc[3'(SEND_LAST - 7'd1 - cnt_q)];
            end
        end
    end

    assign pad_oe      = (state_q == ST_SEND);
    assign pad_enable  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign timeout_err = tmo_q;
    assign crc_err     = crc_err_q;
    assign frame_err   = frm_err_q;
    assign resp_index  = resp_index_q;
    assign resp_arg    = resp_arg_q;

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Bench for sd_cmd_phy: per-cycle expectations derived from the frame/timeline
// rules are queued by the stimulus and compared at every falling edge.
module tb_sd_cmd_phy;

    logic        sd_clock = 1'b0;
    logic        reset_n, strobe_in, resp_expected, crc_check_en, ack_in, pad_data_in;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        pad_oe, pad_enable, pad_data_out, busy, done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        timeout_err, crc_err, frame_err;

    always #5 sd_clock = ~sd_clock;

    sd_cmd_phy dut (
        .sd_clock      (sd_clock),
        .reset_n       (reset_n),
        .strobe_in     (strobe_in),
        .cmd_index     (cmd_index),
        .cmd_arg       (cmd_arg),
        .resp_expected (resp_expected),
        .crc_check_en  (crc_check_en),
        .ack_in        (ack_in),
        .pad_oe        (pad_oe),
        .pad_enable    (pad_enable),
        .pad_data_out  (pad_data_out),
        .pad_data_in   (pad_data_in),
        .busy          (busy),
        .done          (done),
        .resp_index    (resp_index),
        .resp_arg      (resp_arg),
        .timeout_err   (timeout_err),
        .crc_err       (crc_err),
        .frame_err     (frame_err)
    );

    typedef struct packed {
        bit        oe, en, dout, busy, done;
        bit        chk_dout, chk_flags, chk_resp;
        bit        tmo, crc, frm;
        bit [5:0]  idx;
        bit [31:0] arg;
    } exp_t;

    exp_t        expq[$];
    int          errors = 0;
    int          checks = 0;
    int          frames = 0;
    int          exp_frames = 0;
    logic [47:0] sent = '0;
    logic        oe_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // CRC7 as remainder of (msg * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] crc7_model(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] frame_of(input logic [1:0] hdr, input logic [5:0] idx,
                                             input logic [31:0] arg);
        logic [39:0] m;
        m = {hdr, idx, arg};
        return {m, crc7_model(m), 1'b1};
    endfunction

    always @(negedge sd_clock) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("busy", busy, e.busy);
            chk("pad_oe", pad_oe, e.oe);
            chk("pad_enable", pad_enable, e.en);
            chk("done", done, e.done);
            if (e.chk_dout) chk("pad_data_out", pad_data_out, e.dout);
            if (e.chk_flags) begin
                chk("timeout_err", timeout_err, e.tmo);
                chk("crc_err", crc_err, e.crc);
                chk("frame_err", frame_err, e.frm);
            end
            if (e.chk_resp) begin
                chk("resp_index", resp_index, e.idx);
                chk("resp_arg", resp_arg, e.arg);
            end
            if (e.oe) sent = {sent[46:0], pad_data_out};
            if (pad_oe && !oe_prev) frames++;
            oe_prev = pad_oe;
        end
    end

    task automatic tick(input exp_t e);
        expq.push_back(e);
        @(posedge sd_clock);
        #1;
    endtask

    function automatic exp_t reset_e();
        exp_t e;
        e = '0;
        e.dout = 1'b1;
        e.chk_dout = 1'b1;
        e.chk_flags = 1'b1;
        e.chk_resp = 1'b1;
        return e;
    endfunction

    function automatic exp_t active_e(input bit oe);
        exp_t e;
        e = '0;
        e.oe = oe;
        e.en = 1'b1;
        e.busy = 1'b1;
        return e;
    endfunction

    // One command transaction; strobe_at/abort_at < 0 disable those events,
    // delay >= 64 leaves the line idle for a response timeout.
    task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input bit rexp,
                           input bit cen, input int delay, input logic [47:0] resp,
                           input int strobe_at, input bit ack_with_strobe, input int abort_at);
        exp_t        e;
        logic [47:0] fr;
        bit          tmo, crc, frm, got;
        fr = frame_of(2'b01, idx, arg);
        tmo = 0; crc = 0; frm = 0; got = 0;
        cmd_index = idx; cmd_arg = arg; resp_expected = rexp; crc_check_en = cen;
        strobe_in = 1'b1;
        tick(exp_t'('0));
        strobe_in = 1'b0;
        cmd_index = ~idx; cmd_arg = ~arg;
        exp_frames++;
        for (int i = 0; i < 48; i++) begin
            if (i == strobe_at) strobe_in = 1'b1;
            if (i == abort_at) reset_n = 1'b0;
            e = active_e(1'b1);
            e.chk_dout = 1'b1;
            e.dout = fr[47-i];
            tick(e);
            strobe_in = 1'b0;
            if (i == abort_at) begin
                reset_n = 1'b1;
                tick(reset_e());
                return;
            end
        end
        if (rexp) begin
            pad_data_in = 1'b1;
            for (int i = 0; i < 2; i++) tick(active_e(1'b0));
            for (int w = 0; w < delay && w < 64; w++) tick(active_e(1'b0));
            if (delay >= 64) begin
                tmo = 1;
            end else begin
                pad_data_in = 1'b0;
                tick(active_e(1'b0));
                for (int i = 46; i >= 0; i--) begin
                    pad_data_in = resp[i];
                    tick(active_e(1'b0));
                end
                pad_data_in = 1'b1;
                tick(active_e(1'b0));
                frm = resp[46] | ~resp[0];
                crc = cen && (resp[7:1] != crc7_model(resp[47:8]));
                got = 1;
            end
        end
        e = '0;
        e.busy = 1'b1; e.done = 1'b1; e.chk_flags = 1'b1;
        e.tmo = tmo; e.crc = crc; e.frm = frm;
        e.chk_resp = got; e.idx = resp[45:40]; e.arg = resp[39:8];
        for (int k = 0; k < 3; k++) tick(e);
        strobe_in = ack_with_strobe;
        ack_in = 1'b1;
        tick(e);
        ack_in = 1'b0; strobe_in = 1'b0;
        for (int k = 0; k < 3; k++) tick(exp_t'('0));
    endtask

    initial begin
        logic [47:0] r1;
        reset_n = 1'b0; strobe_in = 1'b0; ack_in = 1'b0; pad_data_in = 1'b1;
        resp_expected = 1'b0; crc_check_en = 1'b1; cmd_index = '0; cmd_arg = '0;
        @(posedge sd_clock);
        #1;
        tick(reset_e());
        reset_n = 1'b1;
        tick(reset_e());

        chk("model_cmd0", frame_of(2'b01, 6'd0, 32'h0), 48'h400000000095);
        chk("model_cmd17", frame_of(2'b01, 6'd17, 32'h0), 48'h510000000055);

        // CMD0, no response, stray strobe during SEND
        run_cmd(6'd0, 32'h0, 1'b0, 1'b1, 0, 48'h0, 10, 1'b0, -1);
        chk("cmd0_stream", sent, 48'h400000000095);

        // CMD17 with valid R1
        r1 = frame_of(2'b00, 6'd17, 32'h0000_0900);
        run_cmd(6'd17, 32'h0, 1'b1, 1'b1, 5, r1, -1, 1'b0, -1);
        chk("cmd17_stream", sent, 48'h510000000055);

        // One CRC bit flipped, checked and unchecked; ack together with strobe
        run_cmd(6'd17, 32'h0, 1'b1, 1'b1, 3, r1 ^ 48'h2, -1, 1'b1, -1);
        run_cmd(6'd17, 32'h0, 1'b1, 1'b0, 3, r1 ^ 48'h2, -1, 1'b0, -1);

        // Framing errors: transmission bit 1, then end bit 0
        run_cmd(6'd13, 32'hA5A5_0001, 1'b1, 1'b1, 0, frame_of(2'b01, 6'd13, 32'h1), -1, 1'b0, -1);
        run_cmd(6'd13, 32'hA5A5_0001, 1'b1, 1'b1, 63, frame_of(2'b00, 6'd13, 32'h2) ^ 48'h1,
                -1, 1'b0, -1);

        // Response timeout
        run_cmd(6'd8, 32'h0000_01AA, 1'b1, 1'b1, 100, 48'h0, -1, 1'b0, -1);

        // Reset at bit 20 of SEND, then a full frame
        run_cmd(6'd55, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 48'h0, -1, 1'b0, 20);
        run_cmd(6'd55, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, 48'h0, -1, 1'b0, -1);
        chk("cmd55_stream", sent, frame_of(2'b01, 6'd55, 32'hDEAD_BEEF));

        // R3-style response with all-ones CRC field and checking disabled
        run_cmd(6'd41, 32'h40FF_8000, 1'b1, 1'b0, 1, 48'h3F80FF8000FF, -1, 1'b0, -1);

        chk("frame_count", frames, exp_frames);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
